// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch front end: widths, PC step,
// default reset vector and the fetch-stream state encoding.
package inst_fetch_unit_pkg;

    localparam int          INST_W           = 32;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        RESET_S = 2'd0,
        RUN     = 2'd1,
        FLUSH   = 2'd2
    } fetch_state_e;

    // Branch targets are word aligned by dropping the byte offset.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fetch_unit_fifo.sv
// DEPTH-entry synchronous FIFO of {inst, pc} pairs; flush beats push and pop.
module inst_fetch_fifo
    import inst_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [2*INST_W-1:0]        push_data_i,
    input  logic                       pop_i,
    output logic [2*INST_W-1:0]        head_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [2*INST_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]      count_q, count_d;
    logic                do_push_s, do_pop_s;

    assign empty_o = (count_q == {(PTR_W+1){1'b0}});
    assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
    assign count_o = count_q;

    // Qualified push/pop and next pointer/count state.
    always_comb begin
        do_push_s = push_i && !full_o;
        do_pop_s  = pop_i && !empty_o;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush_i) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {(PTR_W+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {(PTR_W+1){1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the slot is unoccupied.
    always_ff @(posedge clk) begin
        if (do_push_s && !flush_i && !rst) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    // Head is forced to zero when empty so an idle interface reads as all zeros.
    always_comb begin
        if (empty_o) begin
            head_o = {(2*INST_W){1'b0}};
        end else begin
            head_o = mem_q[rd_ptr_q];
        end
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction-fetch front end: PC, ROM request tracking and instruction FIFO.
// Defining INST_FETCH_PERF_EN adds the perf_fetch_cnt / perf_stall_cnt counters.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter int          ADDR_W   = 6,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [31:0]       rom_data,
    output logic [31:0]       inst_code,
    output logic [31:0]       inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              redirect,
    input  logic [31:0]       redirect_pc
`ifdef INST_FETCH_PERF_EN
    ,
    output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e        state_q, state_d;
    logic [31:0]         fetch_pc_q, fetch_pc_d;
    logic [31:0]         req_pc_q, req_pc_d;
    logic                inflight_q, inflight_d;
    logic [CNT_W-1:0]    fifo_count_s;
    logic                fifo_empty_s, fifo_full_s;
    logic [CNT_W:0]      occupancy_s;
    logic                pop_s, push_s, issue_s, discard_s;
    logic [2*INST_W-1:0] head_s;

    assign rom_addr   = fetch_pc_q[ADDR_W+1:2];
    assign inst_valid = !fifo_empty_s;
    assign inst_code  = head_s[2*INST_W-1:INST_W];
    assign inst_pc    = head_s[INST_W-1:0];

    // Fetch-stream state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RESET_S;
        end else begin
            state_q <= state_d;
        end
    end

    // Fetch-stream next state; any redirect parks the stream in FLUSH for a cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RESET_S: state_d = redirect ? FLUSH : RUN;
            RUN:     state_d = redirect ? FLUSH : RUN;
            FLUSH:   state_d = redirect ? FLUSH : RUN;
            default: state_d = RESET_S;
        endcase
    end

    // Fetch-stream outputs: a return seen in FLUSH belongs to the old stream.
    always_comb begin
        discard_s = 1'b0;
        case (state_q)
            FLUSH:   discard_s = 1'b1;
            default: discard_s = 1'b0;
        endcase
    end

    // Issue only if the slot is guaranteed free when the response returns.
    always_comb begin
        pop_s       = inst_valid && inst_ready;
        push_s      = inflight_q && !discard_s && !fifo_full_s;
        occupancy_s = {1'b0, fifo_count_s} + {{CNT_W{1'b0}}, inflight_q}
                      - {{CNT_W{1'b0}}, pop_s};
        issue_s     = !redirect && (occupancy_s < (CNT_W+1)'(DEPTH));
    end

    // PC and in-flight request next state.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = 1'b0;
        if (redirect) begin
            fetch_pc_d = align_pc(redirect_pc);
        end else if (issue_s) begin
            inflight_d = 1'b1;
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end else begin
            inflight_d = 1'b0;
        end
    end

    // PC and in-flight request registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= 32'h0000_0000;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    inst_fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect),
        .push_i      (push_s),
        .push_data_i ({rom_data, req_pc_q}),
        .pop_i       (pop_s),
        .head_o      (head_s),
        .count_o     (fifo_count_s),
        .empty_o     (fifo_empty_s),
        .full_o      (fifo_full_s)
    );

`ifdef INST_FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_stall_q;

    // Delivered-instruction and back-pressure counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_q <= 32'd0;
            perf_stall_q <= 32'd0;
        end else begin
            if (pop_s) begin
                perf_fetch_q <= perf_fetch_q + 32'd1;
            end
            if (inst_valid && !inst_ready) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios plus random
// ready/redirect/reset traffic checked against a queue-based reference model.
module tb_inst_fetch_unit;
    localparam int          ADDR_W   = 6;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] rom_addr;
    logic [31:0]       rom_data = 32'h0;
    logic [31:0]       inst_code;
    logic [31:0]       inst_pc;
    logic              inst_valid;
    logic              inst_ready = 1'b0;
    logic              redirect = 1'b0;
    logic [31:0]       redirect_pc = 32'h0;
`ifdef INST_FETCH_PERF_EN
    logic [31:0]       perf_fetch_cnt;
    logic [31:0]       perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    inst_fetch_unit #(
        .ADDR_W   (ADDR_W),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .inst_code   (inst_code),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
`ifdef INST_FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    // Synchronous-read ROM, word k holds 0x1000_0000 + k.
    logic [31:0] rom [64];
    always @(posedge clk) rom_data <= rom[rom_addr];

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: queue of delivered-in-order PCs plus one pending request.
    logic [31:0] mq[$];
    bit          m_pend = 1'b0;
    logic [31:0] m_pend_pc = 32'h0;
    logic [31:0] m_pc = RESET_PC;
    logic [31:0] m_fetch = 32'h0;
    logic [31:0] m_stall = 32'h0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] code_for(input logic [31:0] pc);
        logic [31:0] word;
        word = (pc >> 2) & 32'd63;
        return 32'h1000_0000 + word;
    endfunction

    task automatic model_step();
        bit pop;
        bit iss;
        int occ;
        if (rst) begin
            mq.delete();
            m_pend  = 1'b0;
            m_pc    = RESET_PC;
            m_fetch = 32'h0;
            m_stall = 32'h0;
        end else begin
            pop = (mq.size() > 0) && inst_ready;
            if (pop) m_fetch = m_fetch + 32'd1;
            if ((mq.size() > 0) && !inst_ready) m_stall = m_stall + 32'd1;
            if (redirect) begin
                mq.delete();
                m_pend = 1'b0;
                m_pc   = {redirect_pc[31:2], 2'b00};
            end else begin
                occ = mq.size() + int'(m_pend) - int'(pop);
                iss = occ < DEPTH;
                if (pop) void'(mq.pop_front());
                if (m_pend) mq.push_back(m_pend_pc);
                m_pend = iss;
                if (iss) begin
                    m_pend_pc = m_pc;
                    m_pc      = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic compare_model();
        check_val("valid", 64'(inst_valid), 64'(mq.size() > 0));
        check_val("rom_addr", 64'(rom_addr), 64'(m_pc[7:2]));
        if (mq.size() > 0) begin
            check_val("pc", 64'(inst_pc), 64'(mq[0]));
            check_val("code", 64'(inst_code), 64'(code_for(mq[0])));
        end
`ifdef INST_FETCH_PERF_EN
        check_val("perf_fetch", 64'(perf_fetch_cnt), 64'(m_fetch));
        check_val("perf_stall", 64'(perf_stall_cnt), 64'(m_stall));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_model();
    endtask

    initial begin
        for (int k = 0; k < 64; k++) rom[k] = 32'h1000_0000 + 32'(k);

        @(negedge clk);
        tick();
        tick();
        check_val("rst_valid", 64'(inst_valid), 64'd0);
        check_val("rst_code", 64'(inst_code), 64'd0);
        check_val("rst_pc", 64'(inst_pc), 64'd0);

        // Start-up latency and back-to-back delivery.
        rst = 1'b0;
        inst_ready = 1'b1;
        tick();
        check_val("lat_c1_valid", 64'(inst_valid), 64'd0);
        tick();
        check_val("lat_c2_valid", 64'(inst_valid), 64'd1);
        check_val("lat_c2_pc", 64'(inst_pc), 64'h0);
        check_val("lat_c2_code", 64'(inst_code), 64'h1000_0000);
        tick();
        check_val("seq_pc4", 64'(inst_pc), 64'h4);
        tick();
        check_val("seq_pc8", 64'(inst_pc), 64'h8);

        // Stall at pc 8 for five cycles.
        inst_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_val("stall_code", 64'(inst_code), 64'h1000_0002);
        end
        inst_ready = 1'b1;
        tick();
        check_val("release_pc", 64'(inst_pc), 64'hC);
        tick();
        check_val("release_pc2", 64'(inst_pc), 64'h10);

        // Redirect with a full FIFO; unaligned target.
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        redirect = 1'b1;
        redirect_pc = 32'h0000_0021;
        tick();
        redirect = 1'b0;
        inst_ready = 1'b1;
        check_val("redir_t1_valid", 64'(inst_valid), 64'd0);
        tick();
        check_val("redir_t2_valid", 64'(inst_valid), 64'd0);
        tick();
        check_val("redir_t3_valid", 64'(inst_valid), 64'd1);
        check_val("redir_t3_pc", 64'(inst_pc), 64'h20);
        check_val("redir_t3_code", 64'(inst_code), 64'h1000_0008);

        // Back-to-back redirects: the second one wins.
        redirect = 1'b1;
        redirect_pc = 32'h0000_0040;
        tick();
        redirect_pc = 32'h0000_0080;
        tick();
        redirect = 1'b0;
        tick();
        tick();
        check_val("dbl_redir_pc", 64'(inst_pc), 64'h80);
        check_val("dbl_redir_valid", 64'(inst_valid), 64'd1);

        // ROM address wrap.
        redirect = 1'b1;
        redirect_pc = 32'h0000_00FC;
        tick();
        redirect = 1'b0;
        check_val("wrap_addr63", 64'(rom_addr), 64'd63);
        tick();
        check_val("wrap_addr0", 64'(rom_addr), 64'd0);
        tick();
        check_val("wrap_pc_fc", 64'(inst_pc), 64'hFC);
        check_val("wrap_code_fc", 64'(inst_code), 64'h1000_003F);
        tick();
        check_val("wrap_pc_100", 64'(inst_pc), 64'h100);
        check_val("wrap_code_100", 64'(inst_code), 64'h1000_0000);

        // Random traffic including 32-bit PC wrap and occasional resets.
        for (int i = 0; i < 400; i++) begin
            inst_ready  = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                                      : $urandom;
            rst         = ($urandom_range(0, 99) == 0);
            tick();
        end

        // Reset mid-stream.
        rst = 1'b0;
        redirect = 1'b0;
        inst_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check_val("pre_rst_valid", 64'(inst_valid), 64'd1);
        rst = 1'b1;
        tick();
        check_val("mid_rst_valid", 64'(inst_valid), 64'd0);
`ifdef INST_FETCH_PERF_EN
        check_val("mid_rst_perf_fetch", 64'(perf_fetch_cnt), 64'd0);
        check_val("mid_rst_perf_stall", 64'(perf_stall_cnt), 64'd0);
`endif
        rst = 1'b0;
        tick();
        tick();
        check_val("restart_valid", 64'(inst_valid), 64'd1);
        check_val("restart_pc", 64'(inst_pc), 64'(RESET_PC));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction-fetch front end that produces the 32-bit instruction word consumed by the single-cycle CPU core.
- Holds the PC and issues word addresses to a synchronous-read instruction ROM (block RAM, 1-cycle read latency).
- Buffers returned words with their PCs in a small FIFO and presents them to the core over a valid/ready handshake.
- Accepts a redirect (branch/jump target) from the core and flushes in-flight work.

Parameters:
- ADDR_W, 6, ROM word-address width; rom_addr = fetch_pc[ADDR_W+1:2].
- DEPTH, 2, instruction FIFO depth; power of two, minimum 2.
- RESET_PC, 32'h0000_0000, PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- rom_addr  out  ADDR_W  word address to instruction ROM; read issued every cycle.
- rom_data  in  32  ROM read data; valid one cycle after the address was presented.
- inst_code  out  32  instruction at FIFO head.
- inst_pc  out  32  byte PC of inst_code.
- inst_valid  out  1  FIFO non-empty.
- inst_ready  in  1  core accepts head this cycle; a pop occurs when inst_valid && inst_ready.
- redirect  in  1  load new PC and flush.
- redirect_pc  in  32  target byte address; bits [1:0] are ignored and treated as 0.

Behaviour:
- Reset (rst=1 at an edge):
  - fetch_pc <= RESET_PC; FIFO emptied; in-flight flag cleared.
  - inst_valid=0, inst_code=0, inst_pc=0.
  - Reset overrides redirect and all handshakes.
- Issue condition at cycle n: !redirect && (count + inflight - pop) < DEPTH.
  - On issue: inflight <= 1, req_pc <= fetch_pc, fetch_pc <= fetch_pc + 4.
  - When no issue occurs, inflight <= 0.
- Return at cycle n+1: if inflight=1, push {rom_data, req_pc} into the FIFO. The issue condition guarantees the FIFO has room.
- rom_addr is driven combinationally from fetch_pc[ADDR_W+1:2]. Reads with no issue are harmless, and their data is ignored.
- FIFO push and pop may occur in the same cycle; count stays unchanged.
- Latency:
  - First inst_valid appears 2 cycles after the first cycle with rst=0.
  - In steady state with inst_ready held at 1, throughput is one instruction per cycle.
- Stall: while inst_ready=0, inst_code and inst_pc hold stable. Issue stops once count+inflight reaches DEPTH, and no instruction is lost or duplicated.
- Redirect at cycle t (highest priority after rst):
  - FIFO flushed; inflight response discarded; no push at t+1 from the pre-redirect fetch.
  - Any pop at t is ignored, so the core must not rely on an accept in the redirect cycle.
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - Issue resumes at t+1; inst_valid rises at t+3.
- Redirect in consecutive cycles: the last redirect wins.
- Wrap-around:
  - fetch_pc wraps modulo 2^32.
  - rom_addr wraps modulo 2^ADDR_W; inst_pc reports the full 32-bit PC.
- FSM (tracks the fetch stream):
  - States: RESET_S (during rst), RUN (issuing allowed), FLUSH (cycle after redirect: discard return).
  - Transitions: RESET_S→RUN when rst deasserts; RUN→FLUSH on redirect; FLUSH→RUN unless redirect, in which case it stays in FLUSH.

Optional Feature:
- Macro: INST_FETCH_PERF_EN.
- Defined: adds two 32-bit output counters, both cleared by rst and wrapping at 2^32.
  - perf_fetch_cnt: increments on each pop.
  - perf_stall_cnt: increments each cycle with inst_valid && !inst_ready.
- Undefined: neither port nor counter logic exists, and behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - INST_W=32.
  - PC_STEP=32'd4.
  - The default reset vector.
  - The fetch state encoding (RESET_S, RUN, FLUSH).
- One sub-module: inst_fetch_fifo.
  - Contents: DEPTH-entry synchronous FIFO of {inst[31:0], pc[31:0]}.
  - Controls: push, pop and flush, with flush having priority.
  - Status outputs: count, empty and full.

Test Plan:
- Reset then inst_ready=1; ROM word k = 32'h1000_0000+k:
  - inst_valid first at cycle 2 after rst drops.
  - Instructions 0x10000000, 0x10000001, … appear at inst_pc 0, 4, 8, …, one per cycle.
- inst_ready=0 for 5 cycles mid-stream at inst_pc=8:
  - inst_code stays 0x10000002 for all 5 cycles.
  - After release, the sequence continues at pc 12 with no gap beyond one refill cycle and no duplicates.
- Redirect to 32'h0000_0021 while the FIFO is full:
  - FIFO flushed; next valid instruction has inst_pc=32'h20 and inst_code=0x10000008, arriving 3 cycles after the redirect.
  - No stale pc 12/16 appears.
- Redirect on two consecutive cycles (0x40 then 0x80): only pc 0x80 onward is delivered.
- Wrap: redirect to 32'h0000_00FC with ADDR_W=6:
  - Delivered pcs are 0xFC then 0x100.
  - rom_addr goes 63→0, and inst_code for pc 0x100 equals ROM word 0.
- rst asserted mid-stream with inst_valid=1:
  - Next cycle inst_valid=0 and perf counters=0 (with INST_FETCH_PERF_EN).
  - Fetch restarts at RESET_PC.
